// File: rtl/lives_controller.sv
// ============================================================================
// lives_controller
//
// Player-life manager for the game core. Tracks remaining lives, removes one
// life per collision rising edge and adds one per bonus rising edge (clamped
// to MAX_LIVES). After each accepted hit a timed invulnerability window is
// opened, during which collision edges are ignored and a blink phase is
// offered to the sprite renderer. Reaching zero lives enters the game-over
// state, which only a start request or reset can leave.
//
// Parameters
//   LIVES_W        width of the lives count
//   START_LIVES    lives loaded on reset and on i_Start
//   MAX_LIVES      ceiling for bonus awards (START_LIVES <= MAX_LIVES < 2**LIVES_W)
//   INVULN_CYCLES  length of the post-hit window in clocks (>= 1)
//   CNT_W          width of the window timer (INVULN_CYCLES <= 2**CNT_W)
//   BLINK_BIT      timer bit that selects the blink phase (< CNT_W)
//
// Ports
//   i_Clk           in   system clock, rising edge
//   i_Reset_n       in   asynchronous active-low reset
//   i_Start         in   level: reload lives, start a new game
//   i_Collision     in   level from collision detector, rising edge acts
//   i_Bonus         in   level from score logic, rising edge acts
//   o_Lives         out  current lives
//   o_Invulnerable  out  high during the post-hit window
//   o_Blink         out  sprite-hide phase, 0 outside the window
//   o_Hit           out  one-cycle pulse when a life is removed
//   o_Game_Over     out  high while lives = 0
//
// All outputs are registers or decodes of registers; no input reaches an
// output combinationally.
// ============================================================================
module lives_controller #(
    parameter int LIVES_W       = 4,
    parameter int START_LIVES   = 3,
    parameter int MAX_LIVES     = 9,
    parameter int INVULN_CYCLES = 25000000,
    parameter int CNT_W         = 25,
    parameter int BLINK_BIT     = 22
) (
    input  logic               i_Clk,
    input  logic               i_Reset_n,
    input  logic               i_Start,
    input  logic               i_Collision,
    input  logic               i_Bonus,
    output logic [LIVES_W-1:0] o_Lives,
    output logic               o_Invulnerable,
    output logic               o_Blink,
    output logic               o_Hit,
    output logic               o_Game_Over
);

    localparam logic [LIVES_W-1:0] START_VAL  = LIVES_W'(START_LIVES);
    localparam logic [LIVES_W:0]   MAX_WIDE   = (LIVES_W + 1)'(MAX_LIVES);
    localparam logic [LIVES_W-1:0] MAX_VAL    = LIVES_W'(MAX_LIVES);
    localparam logic [CNT_W-1:0]   TIMER_LOAD = CNT_W'(INVULN_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_ALIVE  = 2'd0,
        ST_INVULN = 2'd1,
        ST_OVER   = 2'd2
    } state_t;

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    state_t             r_state;
    logic [LIVES_W-1:0] r_lives;
    logic [CNT_W-1:0]   r_timer;
    logic               r_hit;
    logic               r_col_d;
    logic               r_bon_d;

    // ------------------------------------------------------------------
    // Combinational next-state signals
    // ------------------------------------------------------------------
    state_t             w_state_nxt;
    logic [LIVES_W-1:0] w_lives_nxt;
    logic [CNT_W-1:0]   w_timer_nxt;
    logic               w_hit_nxt;

    logic               w_hit_e;
    logic               w_bon_e;
    logic               w_h;
    logic               w_b;
    logic [LIVES_W:0]   w_sum;
    logic [LIVES_W-1:0] w_lives_sat;

    // Edge detectors run in every state, so a level held through the end
    // of the window does not look like a fresh edge when ALIVE resumes.
    assign w_hit_e = i_Collision & ~r_col_d;
    assign w_bon_e = i_Bonus & ~r_bon_d;

    // Accepted hit / bonus for this cycle.
    assign w_h = w_hit_e & (r_state == ST_ALIVE);
    assign w_b = w_bon_e & (r_state != ST_OVER);

    // One extra bit of headroom so the +1 at the top of the range is seen
    // before saturation.
    assign w_sum = {1'b0, r_lives}
                 + {{LIVES_W{1'b0}}, w_b}
                 - {{LIVES_W{1'b0}}, w_h};

    // Saturate to [0, MAX_LIVES]. The zero clamp only matters if the game
    // is configured to start with zero lives and a hit arrives in ALIVE.
    always_comb begin
        w_lives_sat = w_sum[LIVES_W-1:0];
        if (w_h && !w_b && (r_lives == '0)) begin
            w_lives_sat = '0;
        end else if (w_sum > MAX_WIDE) begin
            w_lives_sat = MAX_VAL;
        end
    end

    // ------------------------------------------------------------------
    // Next-state / next-value logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_lives_nxt = r_lives;
        w_timer_nxt = r_timer;
        w_hit_nxt   = 1'b0;

        if (i_Start) begin
            // Start wins over any edge arriving in the same cycle.
            w_state_nxt = ST_ALIVE;
            w_lives_nxt = START_VAL;
            w_timer_nxt = '0;
        end else begin
            w_lives_nxt = w_lives_sat;

            if (w_h) begin
                w_hit_nxt = 1'b1;
                if (w_lives_sat == '0) begin
                    w_state_nxt = ST_OVER;
                    w_timer_nxt = '0;
                end else begin
                    // A simultaneous bonus keeps lives non-zero, so the
                    // window still opens.
                    w_state_nxt = ST_INVULN;
                    w_timer_nxt = TIMER_LOAD;
                end
            end else begin
                case (r_state)
                    ST_INVULN: begin
                        // The cycle that shows timer = 0 is the last one in
                        // the window; the next cycle is ALIVE again.
                        if (r_timer == '0) begin
                            w_state_nxt = ST_ALIVE;
                        end else begin
                            w_timer_nxt = r_timer - CNT_W'(1);
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge i_Clk or negedge i_Reset_n) begin
        if (!i_Reset_n) begin
            r_state <= ST_ALIVE;
            r_lives <= START_VAL;
            r_timer <= '0;
            r_hit   <= 1'b0;
            r_col_d <= 1'b0;
            r_bon_d <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_lives <= w_lives_nxt;
            r_timer <= w_timer_nxt;
            r_hit   <= w_hit_nxt;
            r_col_d <= i_Collision;
            r_bon_d <= i_Bonus;
        end
    end

    // ------------------------------------------------------------------
    // Output decode
    // ------------------------------------------------------------------
    assign o_Lives        = r_lives;
    assign o_Hit          = r_hit;
    assign o_Invulnerable = (r_state == ST_INVULN);
    assign o_Game_Over    = (r_state == ST_OVER);
    assign o_Blink        = (r_state == ST_INVULN) & ~r_timer[BLINK_BIT];

endmodule

// File: doc/lives_controller.md
# lives_controller

Parametrised player-life manager for the game core: tracks remaining lives, removes one per collision edge and adds one per bonus edge, clamped to a ceiling. After each hit it grants a timed invulnerability window with a blink output for the sprite renderer. It flags game over and reloads on a start request. It sits between the collision detector / score logic and the HUD and sprite-draw blocks.

## Interface
- LIVES_W, 4: width of the lives count.
- START_LIVES, 3: value loaded on reset and on i_Start.
- MAX_LIVES, 9: ceiling for bonus awards. Legal range is START_LIVES ≤ MAX_LIVES < 2**LIVES_W.
- INVULN_CYCLES, 25000000: length of the post-hit invulnerability window in clocks. Must be ≥ 1.
- CNT_W, 25: width of the window timer. Requires INVULN_CYCLES ≤ 2**CNT_W.
- BLINK_BIT, 22: timer bit that drives the blink phase. Must be < CNT_W.
- i_Clk  in  1  system clock; all state changes on its rising edge.
- i_Reset_n  in  1  asynchronous, active-low reset.
- i_Start  in  1  level; reload lives and start a new game.
- i_Collision  in  1  level from the collision detector; only its rising edge acts.
- i_Bonus  in  1  level from score logic; only its rising edge acts.
- o_Lives  out  LIVES_W  current lives.
- o_Invulnerable  out  1  high during the post-hit window.
- o_Blink  out  1  sprite-hide phase; always 0 outside the window.
- o_Hit  out  1  one-cycle pulse when a life is removed.
- o_Game_Over  out  1  high while lives = 0.

## Operation
- States:
  - ALIVE: hits are accepted.
  - INVULN: collision edges are ignored; bonus edges are still accepted.
  - OVER: collision and bonus edges are ignored.
- Edge detection:
  - Registered copies col_d and bon_d; both reset to 0 and update every cycle in every state.
  - hit_e = i_Collision & ~col_d.
  - bon_e = i_Bonus & ~bon_d.
  - A collision level held across the end of INVULN produces no hit; a new rising edge is required.
- Priority per cycle: i_Start first, then hit/bonus arithmetic.
- i_Start, any state: o_Lives = START_LIVES, state goes to ALIVE, timer = 0, o_Hit = 0. Any hit_e/bon_e in the same cycle is discarded.
- Lives update:
  - next = o_Lives − h + b.
  - h = hit_e and state is ALIVE.
  - b = bon_e and state is not OVER.
  - Compute at LIVES_W+1 bits, then saturate to MAX_LIVES.
  - A bonus at MAX_LIVES is a no-op.
- On an accepted hit (h = 1):
  - o_Hit pulses.
  - If next = 0, state goes to OVER.
  - Otherwise state goes to INVULN and timer loads INVULN_CYCLES − 1.
- Hit and bonus in the same cycle, from ALIVE: net lives unchanged, o_Hit still pulses, state goes to INVULN. A simultaneous bonus therefore prevents game over at 1 life.
- INVULN: timer decrements each cycle. On the cycle timer = 0, state returns to ALIVE.
- OVER: only i_Start or reset leaves this state.
- Output decode:
  - o_Invulnerable = (state is INVULN).
  - o_Game_Over = (state is OVER).
  - o_Blink = INVULN & ~timer[BLINK_BIT].

## Timing
- Reset (i_Reset_n low, immediate and asynchronous):
  - o_Lives = START_LIVES, state ALIVE, timer 0.
  - o_Hit = o_Invulnerable = o_Blink = o_Game_Over = 0.
  - col_d = bon_d = 0.
- Reset mid-window or while in OVER: same values as above.
- A collision level already high when reset releases counts as a rising edge on the first clock.
- Latency: input edge sampled at clock N; o_Lives, o_Hit and state flags change after edge N.
- o_Hit is high for exactly one cycle.
- o_Invulnerable stays high for exactly INVULN_CYCLES cycles after the hit edge.
- The first cycle after the window can accept a new collision edge.
- All outputs are registered or decoded directly from registers, with no input-to-output combinational path.
- A single hit_e or bon_e changes lives by at most 1 per cycle; the simultaneous case nets to zero.

## Test plan
Bench parameters: LIVES_W=4, START_LIVES=3, MAX_LIVES=5, INVULN_CYCLES=8, CNT_W=4, BLINK_BIT=1.
1. Reset, then one collision rising edge → o_Lives 3→2, o_Hit high for one cycle, o_Invulnerable high for exactly 8 cycles, o_Blink pattern 0,0,1,1,0,0,1,1 (timer 7→0).
2. Second collision edge 3 cycles into the window, then i_Collision held high through the window end → no life loss either time; a fresh edge after the window → o_Lives 1.
3. Three spaced hits from 3 → o_Lives 0, o_Game_Over 1, o_Invulnerable 0; further collision/bonus edges → no change; i_Start → o_Lives 3, o_Game_Over 0 next cycle.
4. Five bonus edges from 3 → o_Lives 4, 5, 5, 5, 5 (saturates).
5. At o_Lives 1 in ALIVE, collision and bonus rise in the same cycle → o_Lives stays 1, o_Hit pulses, INVULN entered, no game over. In the same cycle, i_Start with a collision edge → o_Lives 3, no o_Hit.
6. Assert i_Reset_n low mid-window between clock edges → outputs take their reset values immediately. Release with i_Collision high → hit on the first clock, o_Lives 2.
